// File: rtl/morph_window_scheduler.sv
// morph_window_scheduler: streams a raster frame through line buffers into zero-padded 3x3 windows and realigns the datapath result
module morph_window_scheduler #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int OP_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_pixel,
   output logic                    win_valid,
   output logic [9*DATA_WIDTH-1:0] window,
   input  logic [DATA_WIDTH-1:0]   op_result,
   output logic                    out_valid,
   output logic [DATA_WIDTH-1:0]   out_pixel,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);
   localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int SW   = $clog2(NPIX + IMG_WIDTH + 1);
   localparam int CW   = $clog2(IMG_WIDTH);
   localparam int RW   = $clog2(IMG_HEIGHT);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
   state_t                  state_q, state_d;
   logic [SW-1:0]           s_q;
   logic [CW-1:0]           col_q, pc_q, wc_q;
   logic [RW-1:0]           pr_q, wr_q;
   logic [DATA_WIDTH-1:0]   lb1_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   lb2_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   w_q [9];
   logic                    win_valid_q, win_last_q;
   logic [OP_LATENCY-1:0]   vld_sr_q, last_sr_q;
   logic                    out_valid_q, out_last_q, done_q, done_d;
   logic [DATA_WIDTH-1:0]   out_pixel_q;
   logic                    clr, samp, issue;
   logic [DATA_WIDTH-1:0]   x;
   assign clr       = (state_q == IDLE) && start;
   assign samp      = ((state_q == RUN) && in_valid) || (state_q == FLUSH);
   assign x         = (state_q == RUN) ? in_pixel : '0;
   assign issue     = samp && (s_q >= SW'(IMG_WIDTH + 1));
   assign in_ready  = state_q == RUN;
   assign busy      = state_q != IDLE;
   assign win_valid = win_valid_q;
   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   for (genvar k = 0; k < 9; k++) begin : g_win
      assign window[k*DATA_WIDTH +: DATA_WIDTH] =
         ((k < 3 && wr_q == '0) || (k >= 6 && wr_q == RW'(IMG_HEIGHT - 1)) ||
          (k % 3 == 0 && wc_q == '0) || (k % 3 == 2 && wc_q == CW'(IMG_WIDTH - 1))) ? '0 : w_q[k];
   end
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else state_q <= state_d;
   end
   // next state; done fires as the last beat leaves the delay line
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (samp && s_q == SW'(NPIX - 1)) state_d = FLUSH;
         FLUSH:   if (s_q == SW'(NPIX + IMG_WIDTH)) state_d = DRAIN;
         DRAIN:   if (out_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // sample counter, line-buffer column and row/column of the next window centre
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || clr) begin
         s_q         <= '0;
         col_q       <= '0;
         pr_q        <= '0;
         pc_q        <= '0;
         wr_q        <= '0;
         wc_q        <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
      end else begin
         if (samp) begin
            s_q   <= s_q + 1'b1;
            col_q <= (col_q == CW'(IMG_WIDTH - 1)) ? '0 : col_q + 1'b1;
         end
         win_valid_q <= issue;
         if (issue) begin
            wr_q       <= pr_q;
            wc_q       <= pc_q;
            win_last_q <= (pr_q == RW'(IMG_HEIGHT - 1)) && (pc_q == CW'(IMG_WIDTH - 1));
            pc_q       <= (pc_q == CW'(IMG_WIDTH - 1)) ? '0 : pc_q + 1'b1;
            if (pc_q == CW'(IMG_WIDTH - 1)) pr_q <= pr_q + 1'b1;
         end
      end
   end
   // line buffers feed the upper window rows; each sample shifts the 3x3 array left
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || clr) begin
         for (int i = 0; i < IMG_WIDTH; i++) begin
            lb1_q[i] <= '0;
            lb2_q[i] <= '0;
         end
         for (int i = 0; i < 9; i++) w_q[i] <= '0;
      end else if (samp) begin
         lb1_q[col_q] <= x;
         lb2_q[col_q] <= lb1_q[col_q];
         w_q[0] <= w_q[1];
         w_q[1] <= w_q[2];
         w_q[2] <= lb2_q[col_q];
         w_q[3] <= w_q[4];
         w_q[4] <= w_q[5];
         w_q[5] <= lb1_q[col_q];
         w_q[6] <= w_q[7];
         w_q[7] <= w_q[8];
         w_q[8] <= x;
      end
   end
   // valid/last ride alongside the datapath, then the result is registered out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_sr_q    <= '0;
         last_sr_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_pixel_q <= '0;
         done_q      <= 1'b0;
      end else begin
         vld_sr_q    <= OP_LATENCY'({vld_sr_q, win_valid_q});
         last_sr_q   <= OP_LATENCY'({last_sr_q, win_valid_q & win_last_q});
         out_valid_q <= vld_sr_q[OP_LATENCY-1];
         out_last_q  <= last_sr_q[OP_LATENCY-1];
         out_pixel_q <= vld_sr_q[OP_LATENCY-1] ? op_result : '0;
         done_q      <= done_d;
      end
   end
endmodule

// File: tb/tb_morph_window_scheduler.sv
// tb_morph_window_scheduler: two scheduler instances (latency 1 and 3) against a zero-padded 3x3 max reference
module tb_morph_window_scheduler;
   localparam int W = 4, H = 3, N = W * H;
   logic clk = 0, rst = 0, start = 0, in_valid = 0;
   logic [7:0] in_pixel = 0;
   logic in_ready_a, win_valid_a, out_valid_a, out_last_a, busy_a, done_a;
   logic in_ready_b, win_valid_b, out_valid_b, out_last_b, busy_b, done_b;
   logic [71:0] window_a, window_b;
   logic [7:0] op_a, op_b, pb1, pb2, out_pixel_a, out_pixel_b;
   logic [7:0] img [N];
   int total = 0, bad = 0, cyc = 0;
   logic [71:0] win_q [$];
   int win_cyc_a [$], win_cyc_b [$], oc_a [$], oc_b [$], acc_cyc [$];
   logic [7:0] out_a [$], out_b [$], ramp_out [$];
   bit last_a [$], last_b [$];
   int done_cnt_a, done_cnt_b, done_cyc_a;

   morph_window_scheduler #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .OP_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a), .in_pixel(in_pixel),
      .win_valid(win_valid_a), .window(window_a), .op_result(op_a), .out_valid(out_valid_a),
      .out_pixel(out_pixel_a), .out_last(out_last_a), .busy(busy_a), .done(done_a));
   morph_window_scheduler #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .OP_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b), .in_pixel(in_pixel),
      .win_valid(win_valid_b), .window(window_b), .op_result(op_b), .out_valid(out_valid_b),
      .out_pixel(out_pixel_b), .out_last(out_last_b), .busy(busy_b), .done(done_b));

   always #5 clk = ~clk;

   function automatic logic [7:0] wmax(input logic [71:0] w);
      logic [7:0] m = '0;
      for (int k = 0; k < 9; k++) if (w[k*8 +: 8] > m) m = w[k*8 +: 8];
      return m;
   endfunction

   function automatic logic [71:0] exp_win(input int p);
      logic [71:0] v = '0;
      for (int k = 0; k < 9; k++) begin
         int rr, cc;
         rr = p / W + k / 3 - 1;
         cc = p % W + k % 3 - 1;
         if (rr >= 0 && rr < H && cc >= 0 && cc < W) v[k*8 +: 8] = img[rr*W+cc];
      end
      return v;
   endfunction

   function automatic logic [7:0] gold(input int p);
      int m = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = p / W + dr;
            cc = p % W + dc;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W && int'(img[rr*W+cc]) > m) m = int'(img[rr*W+cc]);
         end
      return 8'(m);
   endfunction

   // datapath models: max filter with latency 1 and 3
   always @(posedge clk) begin
      op_a <= wmax(window_a);
      pb1  <= wmax(window_b);
      pb2  <= pb1;
      op_b <= pb2;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (win_valid_a) begin
         win_q.push_back(window_a);
         win_cyc_a.push_back(cyc);
      end
      if (win_valid_b) win_cyc_b.push_back(cyc);
      if (out_valid_a) begin
         out_a.push_back(out_pixel_a);
         last_a.push_back(out_last_a);
         oc_a.push_back(cyc);
      end
      if (out_valid_b) begin
         out_b.push_back(out_pixel_b);
         last_b.push_back(out_last_b);
         oc_b.push_back(cyc);
      end
      if (done_a) begin
         done_cnt_a++;
         done_cyc_a = cyc;
      end
      if (done_b) done_cnt_b++;
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      win_q.delete(); win_cyc_a.delete(); win_cyc_b.delete();
      out_a.delete(); out_b.delete(); last_a.delete(); last_b.delete();
      oc_a.delete(); oc_b.delete(); acc_cyc.delete();
      done_cnt_a = 0; done_cnt_b = 0; done_cyc_a = -1;
   endtask

   // mode 0: always valid, 1: toggled valid, 2: random valid; spurious: RUN step that pulses start
   task automatic run_frame(input int mode, input int spurious);
      int i = 0, k = 0, g = 0;
      bit tog = 1, rdy;
      clear_q();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      while (i < N && g < 500) begin
         in_valid = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         in_pixel = in_valid ? img[i] : 8'($urandom);
         start = (k == spurious);
         rdy = in_ready_a;
         @(posedge clk); #1;
         if (in_valid && rdy) begin
            acc_cyc.push_back(cyc);
            i++;
         end
         k++; g++;
      end
      in_valid = 0;
      start = 0;
      chk("accepted", 96'(i), 96'(N));
      for (int f = 0; f < W + 1; f++) begin
         chk($sformatf("flush%0d ready/busy", f), 96'({in_ready_a, busy_a}), 96'(2'b01));
         acc_cyc.push_back(cyc + 1);
         @(posedge clk); #1;
      end
      g = 0;
      while ((done_cnt_a == 0 || done_cnt_b == 0) && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string tag);
      chk({tag, " beats a"}, 96'(out_a.size()), 96'(N));
      chk({tag, " beats b"}, 96'(out_b.size()), 96'(N));
      chk({tag, " windows"}, 96'(win_q.size()), 96'(N));
      chk({tag, " done a"}, 96'(done_cnt_a), 96'(1));
      chk({tag, " done b"}, 96'(done_cnt_b), 96'(1));
      if (out_a.size() == N && out_b.size() == N && win_q.size() == N && win_cyc_b.size() == N) begin
         for (int p = 0; p < N; p++) begin
            chk($sformatf("%s win p%0d", tag, p), 96'(win_q[p]), 96'(exp_win(p)));
            chk($sformatf("%s pix a p%0d", tag, p), 96'(out_a[p]), 96'(gold(p)));
            chk($sformatf("%s pix b p%0d", tag, p), 96'(out_b[p]), 96'(gold(p)));
            chk($sformatf("%s last a p%0d", tag, p), 96'(last_a[p]), 96'(p == N - 1));
            chk($sformatf("%s last b p%0d", tag, p), 96'(last_b[p]), 96'(p == N - 1));
            chk($sformatf("%s win cyc p%0d", tag, p), 96'(win_cyc_a[p]), 96'(acc_cyc[p+W+1]));
            chk($sformatf("%s lat a p%0d", tag, p), 96'(oc_a[p]), 96'(win_cyc_a[p] + 2));
            chk($sformatf("%s lat b p%0d", tag, p), 96'(oc_b[p]), 96'(win_cyc_b[p] + 4));
         end
         chk({tag, " done cycle"}, 96'(done_cyc_a), 96'(oc_a[N-1] + 1));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset outs a", 96'({in_ready_a, win_valid_a, out_valid_a, out_pixel_a, out_last_a, busy_a, done_a}), 96'(0));
      chk("reset window a", 96'(window_a), 96'(0));
      rst = 1;
      @(posedge clk); #1;

      for (int i = 0; i < N; i++) img[i] = (i == 5) ? 8'd200 : 8'd0;
      run_frame(0, -1);
      check_frame("impulse");

      for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
      run_frame(0, -1);
      check_frame("ramp");
      if (win_q.size() == N) begin
         chk("ramp win p0 const", 96'(win_q[0]), 96'({8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}));
         chk("ramp win p11 const", 96'(win_q[N-1]), 96'({8'd0, 8'd0, 8'd0, 8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7}));
      end
      ramp_out = out_a;

      run_frame(1, -1);
      check_frame("ramp stall");
      chk("stall same as ramp", 96'(out_a == ramp_out), 96'(1));

      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
      run_frame(2, 3);
      check_frame("random spurious start");

      clear_q();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      in_valid = 1;
      for (int i = 0; i < 7; i++) begin
         in_pixel = img[i];
         @(posedge clk); #1;
      end
      rst = 0;
      #1;
      chk("midrst outs a", 96'({in_ready_a, win_valid_a, out_valid_a, out_pixel_a, out_last_a, busy_a, done_a}), 96'(0));
      chk("midrst outs b", 96'({in_ready_b, win_valid_b, out_valid_b, out_pixel_b, out_last_b, busy_b, done_b}), 96'(0));
      chk("midrst window", 96'(window_a), 96'(0));
      #1;
      rst = 1;
      in_valid = 0;
      clear_q();
      repeat (30) @(posedge clk);
      #1;
      chk("after rst beats", 96'(out_a.size() + out_b.size()), 96'(0));
      chk("after rst done", 96'(done_cnt_a + done_cnt_b), 96'(0));
      chk("after rst windows", 96'(win_q.size()), 96'(0));

      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
      run_frame(2, -1);
      check_frame("post reset");

      for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
      run_frame(0, -1);
      check_frame("ramp again");
      chk("back-to-back same", 96'(out_a == ramp_out), 96'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
